// File: rtl/sensor_scan_pkg.sv
// ============================================================================
// Module  : sensor_scan_pkg
// Brief   : Shared types, scan-mode constants and width helper for the sensor
//           scan multiplexer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sensor_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } scan_state_t;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   // Index width that never collapses to zero bits for a count of one.
   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_scan_mux_if.sv
// ============================================================================
// Module  : sensor_scan_mux_if
// Brief   : Sensor-side sample bus and consumer-side valid/ready bus of the
//           scan multiplexer; slave is the mux, master is its environment.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface sensor_scan_mux_if
   import sensor_scan_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int DATA_W = 8
);

   localparam int SEL_W = sel_width(CH_NUM);

   logic [CH_NUM*DATA_W-1:0] in_data;
   logic [CH_NUM-1:0]        in_valid;
   logic [CH_NUM-1:0]        in_ack;
   logic [DATA_W-1:0]        out_data;
   logic [SEL_W-1:0]         out_ch;
   logic                     out_valid;
   logic                     out_ready;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ack,
      output out_data,
      output out_ch,
      output out_valid,
      input  out_ready
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ack,
      input  out_data,
      input  out_ch,
      input  out_valid,
      output out_ready
   );

endinterface

`default_nettype wire

// File: rtl/sensor_scan_ptr.sv
// ============================================================================
// Module  : sensor_scan_ptr
// Brief   : Round-robin channel pointer with per-channel dwell counter;
//           supports fixed-select load, resume-after-capture and dwell skip.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sensor_scan_ptr
   import sensor_scan_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int DWELL  = 4
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load,
   input  logic [sel_width(CH_NUM)-1:0]  load_val,
   input  logic                          resume,
   input  logic [sel_width(CH_NUM)-1:0]  resume_ch,
   input  logic                          step,
   input  logic                          dwell_clr,
   output logic [sel_width(CH_NUM)-1:0]  ptr
);

   localparam int SEL_W = sel_width(CH_NUM);
   localparam int CNT_W = sel_width(DWELL);

   logic [SEL_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_dwell_cnt;
   logic             w_dwell_done;

   function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] ch);
      return (int'(ch) >= CH_NUM - 1) ? '0 : ch + 1'b1;
   endfunction

   assign w_dwell_done = (int'(r_dwell_cnt) >= DWELL - 1);

   // Priority: fixed-select load, resume after a capture, empty-cycle step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_dwell_cnt <= '0;
      end else if (load) begin
         r_ptr       <= load_val;
         r_dwell_cnt <= '0;
      end else if (resume) begin
         r_ptr       <= wrap_inc(resume_ch);
         r_dwell_cnt <= '0;
      end else if (step) begin
         if (w_dwell_done) begin
            r_ptr       <= wrap_inc(r_ptr);
            r_dwell_cnt <= '0;
         end else begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
         end
      end else if (dwell_clr) begin
         r_dwell_cnt <= '0;
      end
   end

   assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/sensor_scan_mux.sv
// ============================================================================
// Module  : sensor_scan_mux
// Brief   : Registered N-channel sensor scan multiplexer (round-robin with
//           dwell skip, or fixed channel) with a valid/ready sample output.
//           Define SCAN_ALARM_EN to add the thresh_hi/alarm threshold check.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sensor_scan_mux
   import sensor_scan_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int DATA_W = 8,
   parameter int DWELL  = 4
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          mode,
   input  logic [sel_width(CH_NUM)-1:0]  fix_sel,
`ifdef SCAN_ALARM_EN
   input  logic [DATA_W-1:0]             thresh_hi,
   output logic                          alarm,
`endif
   sensor_scan_mux_if.slave              bus
);

   localparam int SEL_W = sel_width(CH_NUM);

   scan_state_t       r_state;
   scan_state_t       w_state_nxt;

   logic [SEL_W-1:0]  w_ptr;
   logic [SEL_W-1:0]  w_fix_ch;
   logic [SEL_W-1:0]  w_cur_ch;
   logic              w_hit;
   logic [DATA_W-1:0] w_sample;

   logic              w_capture;
   logic              w_release;
   logic              w_ld;
   logic              w_resume;
   logic              w_step;
   logic              w_dwell_clr;

   logic [DATA_W-1:0] r_out_data;
   logic [SEL_W-1:0]  r_out_ch;
   logic              r_out_valid;

   // Out-of-range fixed selects fall back to channel 0.
   assign w_fix_ch = (int'(fix_sel) < CH_NUM) ? fix_sel : '0;
   assign w_cur_ch = (mode == MODE_FIXED) ? w_fix_ch : w_ptr;
   assign w_hit    = bus.in_valid[w_cur_ch];
   assign w_sample = bus.in_data[w_cur_ch*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_release   = 1'b0;
      w_ld        = 1'b0;
      w_resume    = 1'b0;
      w_step      = 1'b0;
      w_dwell_clr = 1'b0;
      case (r_state)
         IDLE: begin
            if (en) begin
               w_state_nxt = SCAN;
               w_ld        = (mode == MODE_FIXED);
               w_dwell_clr = 1'b1;
            end
         end
         SCAN: begin
            // en wins over a simultaneous in_valid: no ack, no capture.
            if (!en) begin
               w_state_nxt = IDLE;
               w_dwell_clr = 1'b1;
            end else if (w_hit) begin
               w_state_nxt = HOLD;
               w_capture   = 1'b1;
               w_dwell_clr = 1'b1;
            end else if (mode == MODE_RR) begin
               w_step      = 1'b1;
            end else begin
               w_dwell_clr = 1'b1;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               w_release   = 1'b1;
               w_state_nxt = en ? SCAN : IDLE;
               if (mode == MODE_RR) begin
                  w_resume = 1'b1;
               end else if (en) begin
                  w_ld     = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   sensor_scan_ptr #(
      .CH_NUM (CH_NUM),
      .DWELL  (DWELL)
   ) u_ptr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_ld),
      .load_val  (w_fix_ch),
      .resume    (w_resume),
      .resume_ch (r_out_ch),
      .step      (w_step),
      .dwell_clr (w_dwell_clr),
      .ptr       (w_ptr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
      end else if (w_capture) begin
         r_out_data  <= w_sample;
         r_out_ch    <= w_cur_ch;
         r_out_valid <= 1'b1;
      end else if (w_release) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef SCAN_ALARM_EN
   logic r_alarm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alarm <= 1'b0;
      end else if (w_capture) begin
         r_alarm <= (w_sample > thresh_hi);
      end else if (w_release) begin
         r_alarm <= 1'b0;
      end
   end

   assign alarm = r_alarm;
`endif

   assign bus.in_ack    = w_capture ? ({{(CH_NUM-1){1'b0}}, 1'b1} << w_cur_ch) : '0;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;
   assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_sensor_scan_mux.sv
// ============================================================================
// Module  : tb_sensor_scan_mux
// Brief   : Self-checking bench for sensor_scan_mux (directed scenarios plus
//           randomized traffic against a behavioural model).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sensor_scan_mux;

   localparam int CH    = 4;
   localparam int DW    = 8;
   localparam int DWELL = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          en    = 1'b0;
   logic          mode  = 1'b0;
   logic [1:0]    fix_sel = 2'd0;
   logic [2:0]    fix_sel5 = 3'd5;
   logic [DW-1:0] thresh_hi = 8'h80;
   logic          alarm;
   logic          alarm5;

   sensor_scan_mux_if #(.CH_NUM(CH), .DATA_W(DW)) bus ();
   sensor_scan_mux_if #(.CH_NUM(5),  .DATA_W(DW)) bus5 ();

   sensor_scan_mux #(.CH_NUM(CH), .DATA_W(DW), .DWELL(DWELL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .fix_sel   (fix_sel),
`ifdef SCAN_ALARM_EN
      .thresh_hi (thresh_hi),
      .alarm     (alarm),
`endif
      .bus       (bus)
   );

   sensor_scan_mux #(.CH_NUM(5), .DATA_W(DW), .DWELL(DWELL)) dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .fix_sel   (fix_sel5),
`ifdef SCAN_ALARM_EN
      .thresh_hi (thresh_hi),
      .alarm     (alarm5),
`endif
      .bus       (bus5)
   );

`ifndef SCAN_ALARM_EN
   assign alarm  = 1'b0;
   assign alarm5 = 1'b0;
`endif

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: phase 0 idle, 1 scanning, 2 sample pending.
   int       m_phase;
   int       m_ptr;
   int       m_wait;
   int       m_ch;
   bit [7:0] m_data;
   bit       m_valid;
   bit       m_alarm;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int fix_ch();
      return (int'(fix_sel) < CH) ? int'(fix_sel) : 0;
   endfunction

   function automatic int cur_ch();
      return mode ? fix_ch() : m_ptr;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_ptr   = 0;
      m_wait  = 0;
      m_ch    = 0;
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_alarm = 1'b0;
   endtask

   task automatic compare();
      logic [CH-1:0] ea;
      int c;
      ea = '0;
      c  = cur_ch();
      if (m_phase == 1 && en && bus.in_valid[c]) ea[c] = 1'b1;
      chk("ack", 32'(bus.in_ack), 32'(ea));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
         chk("out_data", 32'(bus.out_data), 32'(m_data));
         chk("out_ch", 32'(bus.out_ch), 32'(m_ch));
      end
`ifdef SCAN_ALARM_EN
      chk("alarm", 32'(alarm), 32'(m_alarm));
`endif
   endtask

   task automatic model_step();
      int c;
      c = cur_ch();
      case (m_phase)
         0: if (en) begin
               m_phase = 1;
               m_wait  = 0;
               if (mode) m_ptr = fix_ch();
            end
         1: if (!en) begin
               m_phase = 0;
               m_wait  = 0;
            end else if (bus.in_valid[c]) begin
               m_data  = bus.in_data[c*DW +: DW];
               m_ch    = c;
               m_valid = 1'b1;
               m_alarm = (m_data > thresh_hi);
               m_wait  = 0;
               m_phase = 2;
            end else if (!mode) begin
               m_wait++;
               if (m_wait == DWELL) begin
                  m_wait = 0;
                  m_ptr  = (m_ptr + 1) % CH;
               end
            end else begin
               m_wait = 0;
            end
         default: if (bus.out_ready) begin
               m_valid = 1'b0;
               m_alarm = 1'b0;
               if (!mode) m_ptr = (m_ch + 1) % CH;
               else if (en) m_ptr = fix_ch();
               m_phase = en ? 1 : 0;
            end
      endcase
   endtask

   // Entered one time unit after a rising edge with inputs already applied.
   task automatic tick();
      #3;
      compare();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
      chk("rst_in_ack", 32'(bus.in_ack), 32'd0);
      chk("rst_alarm", 32'(alarm), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] ech [5];
      logic [7:0] edat [5];
      logic [CH-1:0] ackv, acc;
      logic [4:0] acc5;
      int caps, last_i, n;
      bit got;

      bus.in_data   = 32'h44332211;
      bus.in_valid  = 4'hF;
      bus.out_ready = 1'b1;
      bus5.in_data  = 40'h5544332211;
      bus5.in_valid = 5'h1F;
      bus5.out_ready = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Reset state: en low, all channels valid, nothing acknowledged.
      #1;
      chk("idle_ack", 32'(bus.in_ack), 32'd0);
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      tick();

      // Round-robin with every channel valid.
      ech  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      edat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      en = 1'b1; mode = 1'b0; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
      caps = 0; last_i = 0;
      for (int i = 0; i < 11; i++) begin
         tick();
         if (bus.out_valid) begin
            if (caps < 5) begin
               chk("rr_ch", 32'(bus.out_ch), 32'(ech[caps]));
               chk("rr_data", 32'(bus.out_data), 32'(edat[caps]));
               if (caps > 0) chk("rr_spacing", i - last_i, 2);
            end
            caps++;
            last_i = i;
         end
      end
      chk("rr_count", caps, 5);

      // Dwell skip: only channel 2 valid, pointer starting at 0.
      do_reset();
      en = 1'b1; mode = 1'b0; bus.in_valid = 4'b0100; bus.out_ready = 1'b1;
      tick();
      n = 0; got = 1'b0; ackv = '0;
      while (n < 20 && !got) begin
         n++;
         #1;
         if (bus.in_ack != '0) begin
            got  = 1'b1;
            ackv = bus.in_ack;
         end
         tick();
      end
      chk("skip_scan_cycles", n, 9);
      chk("skip_ack", 32'(ackv), 32'h4);
      chk("skip_ch", 32'(bus.out_ch), 32'd2);
      chk("skip_data", 32'(bus.out_data), 32'h33);

      // Backpressure on the pending channel-2 sample.
      bus.out_ready = 1'b0; bus.in_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_ack", 32'(bus.in_ack), 32'd0);
         tick();
         chk("bp_data", 32'(bus.out_data), 32'h33);
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      tick();
      #1;
      chk("bp_resume_ack", 32'(bus.in_ack), 32'h8);
      tick();
      chk("bp_resume_ch", 32'(bus.out_ch), 32'd3);

      // Fixed mode: channel 3 here; out-of-range select 5 on the 5-channel copy.
      do_reset();
      en = 1'b1; mode = 1'b1; fix_sel = 2'd3; bus.in_valid = 4'hF; bus.out_ready = 1'b1;
      acc = '0; acc5 = '0;
      for (int i = 0; i < 12; i++) begin
         #1;
         acc  = acc | bus.in_ack;
         acc5 = acc5 | bus5.in_ack;
         tick();
         if (bus5.out_valid) chk("fix5_data", 32'(bus5.out_data), 32'h11);
      end
      chk("fix_acks", 32'(acc), 32'h8);
      chk("fix5_acks", 32'(acc5), 32'h1);

`ifdef SCAN_ALARM_EN
      do_reset();
      thresh_hi = 8'h80; en = 1'b1; mode = 1'b1; fix_sel = 2'd0;
      bus.in_valid = 4'b0001; bus.in_data = 32'h00000081; bus.out_ready = 1'b1;
      tick();
      tick();
      chk("alarm_hi", 32'(alarm), 32'd1);
      chk("alarm_hi_data", 32'(bus.out_data), 32'h81);
      bus.out_ready = 1'b0; en = 1'b0;
      tick();
      chk("alarm_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("alarm_hold", 32'(alarm), 32'd1);
      bus.out_ready = 1'b1;
      tick();
      chk("alarm_rel_valid", 32'(bus.out_valid), 32'd0);
      chk("alarm_rel", 32'(alarm), 32'd0);
      bus.in_data = 32'h00000080;
      #1;
      chk("alarm_idle_ack", 32'(bus.in_ack), 32'd0);
      tick();
      en = 1'b1;
      tick();
      tick();
      chk("alarm_eq", 32'(alarm), 32'd0);
      chk("alarm_eq_data", 32'(bus.out_data), 32'h80);
`endif

      // Randomized traffic, including asynchronous resets (some mid-HOLD).
      do_reset();
      mode = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         if ($urandom_range(0, 9) == 0) fix_sel = 2'($urandom);
         for (int b = 0; b < CH; b++) bus.in_valid[b] = ($urandom_range(0, 3) == 0);
         bus.in_data   = 32'($urandom);
         bus.out_ready = ($urandom_range(0, 4) < 3);
         thresh_hi     = 8'($urandom);
         if ($urandom_range(0, 299) == 0 || (m_phase == 2 && $urandom_range(0, 99) == 0)) begin
            #1;
            do_reset();
         end else begin
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
